oram_avm_master: RTL and testbench
==================================

Name: oram_avm_master

Overview:
- Avalon-MM initiator that drives the avs_a_* slave port of oram_driver, so bench, CPU-side and DMA logic can issue ORAM accesses through a simple valid/ready command/response interface.
- Serialises one transaction at a time:
  - strobes read or write for one cycle;
  - waits for the ORAM completion pulse;
  - returns read data or a timeout status.

Parameters:
- ADDRESS_WIDTH, 4, byte-address width; matches oram_driver.
- BYTE_WIDTH, 8, bits per byte.
- BYTES_PER_WORD, 4, bytes per bus word.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for completion in WAIT.
- TIMER_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1=write, 0=read.
- cmd_address  in  ADDRESS_WIDTH  byte address.
- cmd_byteenable  in  BYTES_PER_WORD  byte lane enables.
- cmd_writedata  in  BYTES_PER_WORD*BYTE_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_write  out  1  echo of the command's cmd_write.
- rsp_timeout  out  1  transaction timed out.
- rsp_readdata  out  BYTES_PER_WORD*BYTE_WIDTH  read data; 0 for writes and timeouts.
- avm_a_address  out  ADDRESS_WIDTH  to avs_a_address.
- avm_a_byteenable  out  BYTES_PER_WORD  to avs_a_byteenable.
- avm_a_read  out  1  to avs_a_read.
- avm_a_write  out  1  to avs_a_write.
- avm_a_writedata  out  BYTES_PER_WORD*BYTE_WIDTH  to avs_a_writedata.
- avm_a_readdata  in  BYTES_PER_WORD*BYTE_WIDTH  from avs_a_readdata.
- avm_a_done  in  1  single-cycle completion pulse (ORAM output_ready).
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including cmd_ready during the reset cycle.
  - Latched command and watchdog are cleared.
  - Reset mid-transaction abandons it: strobes are low after the reset edge and no response is produced.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch write, byteenable and writedata.
  - Latch address with the low $clog2(BYTES_PER_WORD) bits forced to 0.
  - Next state ISSUE.
- ISSUE (exactly 1 cycle):
  - avm_a_write=latched write and avm_a_read=!latched write; never both high.
  - Address, byteenable and writedata are driven from the latch.
  - Watchdog is cleared.
  - Next state WAIT.
  - avm_a_done is ignored in this state.
- WAIT:
  - Both strobes are low; address, byteenable and writedata stay stable.
  - Watchdog increments each cycle.
  - If avm_a_done=1: capture avm_a_readdata into rsp_readdata for reads (0 for writes), set rsp_timeout=0, go to RESP.
  - Else if watchdog==TIMEOUT_CYCLES-1: set rsp_timeout=1 and rsp_readdata=0, go to RESP.
  - If done and the timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1; rsp_* fields are stable until handshake.
  - cmd_ready=0.
  - On handshake, go to IDLE.
  - avm_a_done pulses arriving in RESP or IDLE are ignored and do not corrupt the response.
- Latency:
  - Command accepted at edge T; strobe high in cycle T+1.
  - Earliest done is sampled at T+2; rsp_valid high at T+3.
  - If rsp_ready is held high, the next command is accepted at T+4 at the earliest.
- Byteenable 0 is still issued unchanged; the master does not filter.
- No cmd_ready in any state other than IDLE, so at most one transaction is outstanding.

Decomposition:
- oram_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - word_t typedef (BYTES_PER_WORD x BYTE_WIDTH packed array);
  - localparam helper for the address alignment width.
- One sub-module, oram_watchdog:
  - TIMER_WIDTH counter with clear, enable and expire output;
  - expire asserted when count==TIMEOUT_CYCLES-1.

Test Plan:
- Read: cmd addr 0x4, done pulsed 5 cycles after the strobe, readdata 0xDEADBEEF -> one avm_a_read pulse with address 0x4; rsp_valid, rsp_readdata=0xDEADBEEF, rsp_timeout=0.
- Write: cmd addr 0x9, byteenable 0xF, writedata 0x12345678 -> avm_a_write single pulse, address 0x8, data held through WAIT; response rsp_write=1, rsp_readdata=0.
- Timeout: TIMEOUT_CYCLES=8, read, done never asserted -> rsp_timeout=1 exactly 8 cycles after entering WAIT; rsp_readdata=0.
- Done and expiry in the same cycle with readdata 0xA5A5A5A5 -> rsp_timeout=0, rsp_readdata=0xA5A5A5A5.
- Backpressure: rsp_ready low for 10 cycles, stray done pulses, cmd_valid held high -> response fields stable, cmd_ready stays 0, no new strobe until the response handshake.
- Reset asserted in WAIT -> next cycle all outputs 0, busy=0, no rsp_valid; a subsequent read completes normally.

Source files
------------

// File: rtl/oram_pkg.sv
// Shared types and helpers for the ORAM Avalon-MM initiator.
package oram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int BYTE_WIDTH_DEFAULT     = 8;
    localparam int BYTES_PER_WORD_DEFAULT = 4;

    typedef logic [BYTES_PER_WORD_DEFAULT-1:0][BYTE_WIDTH_DEFAULT-1:0] word_t;

    // Number of low address bits that select a byte within a bus word.
    function automatic int align_bits(input int bytes_per_word);
        return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 0;
    endfunction

    localparam int ADDR_ALIGN_BITS = align_bits(BYTES_PER_WORD_DEFAULT);

endpackage

// File: rtl/oram_watchdog.sv
// Cycle counter that flags when a transaction has waited too long.
module oram_watchdog
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES + 1)
)
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TIMER_WIDTH-1:0] count;

    // Count enabled cycles; clear takes priority so each transaction starts at zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/oram_avm_master.sv
// Avalon-MM initiator that serialises single ORAM accesses behind a
// valid/ready command and response interface.
module oram_avm_master
    import oram_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 4,
    parameter int BYTE_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES + 1)
)
(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]             cmd_address,
    input  logic [BYTES_PER_WORD-1:0]            cmd_byteenable,
    input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] cmd_writedata,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic                                 rsp_write,
    output logic                                 rsp_timeout,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] rsp_readdata,
    output logic [ADDRESS_WIDTH-1:0]             avm_a_address,
    output logic [BYTES_PER_WORD-1:0]            avm_a_byteenable,
    output logic                                 avm_a_read,
    output logic                                 avm_a_write,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avm_a_writedata,
    input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avm_a_readdata,
    input  logic                                 avm_a_done,
    output logic                                 busy
);

    localparam int DATA_WIDTH = BYTES_PER_WORD * BYTE_WIDTH;
    localparam int ALIGN      = align_bits(BYTES_PER_WORD);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'((1 << ALIGN) - 1);

    state_t                    state;
    state_t                    state_next;
    logic                      lat_write;
    logic [ADDRESS_WIDTH-1:0]  lat_address;
    logic [BYTES_PER_WORD-1:0] lat_byteenable;
    logic [DATA_WIDTH-1:0]     lat_writedata;
    logic                      wd_expire;

    oram_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_WIDTH    (TIMER_WIDTH)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == ISSUE),
        .enable (state == WAIT),
        .expire (wd_expire)
    );

    // State register plus command latch and response capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            lat_write      <= 1'b0;
            lat_address    <= '0;
            lat_byteenable <= '0;
            lat_writedata  <= '0;
            rsp_timeout    <= 1'b0;
            rsp_readdata   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && cmd_valid) begin
                lat_write      <= cmd_write;
                lat_address    <= cmd_address & ALIGN_MASK;
                lat_byteenable <= cmd_byteenable;
                lat_writedata  <= cmd_writedata;
            end
            if (state == WAIT) begin
                if (avm_a_done) begin
                    rsp_timeout  <= 1'b0;
                    rsp_readdata <= lat_write ? '0 : avm_a_readdata;
                end else if (wd_expire) begin
                    rsp_timeout  <= 1'b1;
                    rsp_readdata <= '0;
                end
            end
        end
    end

    // Next-state logic; completion beats the watchdog when both occur together.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid)               state_next = ISSUE;
            ISSUE:                                state_next = WAIT;
            WAIT:    if (avm_a_done || wd_expire) state_next = RESP;
            RESP:    if (rsp_ready)               state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    assign cmd_ready        = (state == IDLE) && !reset;
    assign rsp_valid        = (state == RESP);
    assign rsp_write        = lat_write;
    assign busy             = (state != IDLE);
    assign avm_a_read       = (state == ISSUE) && !lat_write;
    assign avm_a_write      = (state == ISSUE) && lat_write;
    assign avm_a_address    = lat_address;
    assign avm_a_byteenable = lat_byteenable;
    assign avm_a_writedata  = lat_writedata;

endmodule

// File: tb/tb_oram_avm_master.sv
// Directed bench for oram_avm_master with a scoreboard of expected responses.
module tb_oram_avm_master;

    localparam int AW  = 4;
    localparam int BW  = 8;
    localparam int BPW = 4;
    localparam int DW  = BW * BPW;
    localparam int TO  = 8;

    typedef struct {
        logic          write;
        logic          timeout;
        logic [DW-1:0] rdata;
        int            wait_cycles;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_write;
    logic [AW-1:0]  cmd_address;
    logic [BPW-1:0] cmd_byteenable;
    logic [DW-1:0]  cmd_writedata;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_write;
    logic           rsp_timeout;
    logic [DW-1:0]  rsp_readdata;
    logic [AW-1:0]  avm_a_address;
    logic [BPW-1:0] avm_a_byteenable;
    logic           avm_a_read;
    logic           avm_a_write;
    logic [DW-1:0]  avm_a_writedata;
    logic [DW-1:0]  avm_a_readdata;
    logic           avm_a_done;
    logic           busy;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_failed = 0;

    oram_avm_master #(
        .ADDRESS_WIDTH  (AW),
        .BYTE_WIDTH     (BW),
        .BYTES_PER_WORD (BPW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_address      (cmd_address),
        .cmd_byteenable   (cmd_byteenable),
        .cmd_writedata    (cmd_writedata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_write        (rsp_write),
        .rsp_timeout      (rsp_timeout),
        .rsp_readdata     (rsp_readdata),
        .avm_a_address    (avm_a_address),
        .avm_a_byteenable (avm_a_byteenable),
        .avm_a_read       (avm_a_read),
        .avm_a_write      (avm_a_write),
        .avm_a_writedata  (avm_a_writedata),
        .avm_a_readdata   (avm_a_readdata),
        .avm_a_done       (avm_a_done),
        .busy             (busy)
    );

    initial forever #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_strobes"}, 32'({avm_a_read, avm_a_write}), 0);
        checkOutput({tag, "_address"}, 32'(avm_a_address), 0);
        checkOutput({tag, "_byteenable"}, 32'(avm_a_byteenable), 0);
        checkOutput({tag, "_writedata"}, avm_a_writedata, 0);
        checkOutput({tag, "_rsp_fields"}, 32'({rsp_write, rsp_timeout}), 0);
        checkOutput({tag, "_rsp_readdata"}, rsp_readdata, 0);
    endtask

    // Offer one command, play the ORAM side (done_at = WAIT cycle index of the
    // done pulse, negative for never) and stop at the first cycle rsp_valid is high.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [BPW-1:0] be, input logic [DW-1:0] wd,
                                 input int done_at, input logic [DW-1:0] rd);
        exp_t          e;
        logic [AW-1:0] exp_addr;
        int            cycles;
        logic          got;
        exp_addr = addr & 4'hC;
        e.write       = wr;
        e.timeout     = (done_at < 0) || (done_at >= TO);
        e.rdata       = (wr || e.timeout) ? '0 : rd;
        e.wait_cycles = e.timeout ? TO : done_at + 1;
        @(negedge clock);
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr;
        cmd_byteenable = be; cmd_writedata = wd;
        exp_q.push_back(e);
        @(negedge clock);
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_address = ~addr;
        cmd_byteenable = ~be; cmd_writedata = ~wd;
        checkOutput("issue_read", 32'(avm_a_read), 32'(!wr));
        checkOutput("issue_write", 32'(avm_a_write), 32'(wr));
        checkOutput("issue_address", 32'(avm_a_address), 32'(exp_addr));
        checkOutput("issue_byteenable", 32'(avm_a_byteenable), 32'(be));
        checkOutput("issue_writedata", avm_a_writedata, wd);
        cycles = 0;
        got = 1'b0;
        for (int guard = 0; guard < 40; guard++) begin
            @(negedge clock);
            avm_a_done = 1'b0;
            avm_a_readdata = 32'hBAD0BAD0;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            checkOutput("wait_strobes", 32'({avm_a_read, avm_a_write}), 0);
            checkOutput("wait_address", 32'(avm_a_address), 32'(exp_addr));
            checkOutput("wait_writedata", avm_a_writedata, wd);
            if (cycles == done_at) begin
                avm_a_done = 1'b1;
                avm_a_readdata = rd;
            end
            cycles++;
        end
        checkOutput("wait_bound", 32'(got), 1);
        checkOutput("wait_cycles", 32'(cycles), 32'(e.wait_cycles));
    endtask

    // Pop the expected response, hold it under backpressure for hold cycles
    // while poking stray done pulses and commands, then complete the handshake.
    task automatic collectResponse(input int hold);
        exp_t e;
        checkOutput("sb_depth", 32'(exp_q.size()), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int k = 0; k <= hold; k++) begin
            checkOutput("rsp_valid", 32'(rsp_valid), 1);
            checkOutput("rsp_write", 32'(rsp_write), 32'(e.write));
            checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
            checkOutput("rsp_readdata", rsp_readdata, e.rdata);
            if (k > 0) begin
                checkOutput("resp_cmd_ready", 32'(cmd_ready), 0);
                checkOutput("resp_strobes", 32'({avm_a_read, avm_a_write}), 0);
            end
            if (k < hold) begin
                cmd_valid = 1'b1; cmd_write = 1'b0;
                avm_a_done = k[0];
                avm_a_readdata = 32'h11111111;
                @(negedge clock);
            end
        end
        cmd_valid = 1'b0;
        avm_a_done = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("post_busy", 32'(busy), 0);
        checkOutput("post_cmd_ready", 32'(cmd_ready), 1);
        avm_a_done = 1'b1;
        @(negedge clock);
        avm_a_done = 1'b0;
        checkOutput("idle_stray_done", 32'({busy, rsp_valid}), 0);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
        cmd_byteenable = '0; cmd_writedata = '0;
        rsp_ready = 1'b0; avm_a_readdata = '0; avm_a_done = 1'b0;
        repeat (2) @(negedge clock);
        checkAllZero("reset");
        reset = 1'b0;

        applyStimulus(1'b0, 4'h4, 4'hF, 32'h0, 4, 32'hDEADBEEF);
        collectResponse(0);

        applyStimulus(1'b1, 4'h9, 4'hF, 32'h12345678, 2, 32'h55555555);
        collectResponse(0);

        applyStimulus(1'b0, 4'h3, 4'hF, 32'h0, -1, 32'h0);
        collectResponse(0);

        applyStimulus(1'b0, 4'hC, 4'hF, 32'h0, TO - 1, 32'hA5A5A5A5);
        collectResponse(0);

        applyStimulus(1'b0, 4'h6, 4'h0, 32'h0, 1, 32'h0000CAFE);
        collectResponse(10);

        @(negedge clock);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 4'h5;
        cmd_byteenable = 4'hF; cmd_writedata = 32'h0;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_busy_in_wait", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        checkAllZero("midreset");
        reset = 1'b0;

        applyStimulus(1'b0, 4'hE, 4'h3, 32'h0, 0, 32'h13579BDF);
        collectResponse(0);

        checkOutput("sb_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
